fpm_norm_round: RTL and testbench
=================================

Name: fpm_norm_round

Overview:
- Pipelined normalise/round/pack stage directly downstream of the radix-4 Booth mantissa multiplier (MUL).
- Consumes the 48-bit raw significand product, sign and pre-computed product exponent; emits an IEEE-754 single-precision result.
- Rounding is round-to-nearest-even. Subnormals flush to zero.
- Two register stages with valid/ready back-pressure, so the FPM datapath can stall without dropping operands.

Parameters:
- EXP_W, 10, width of signed (two's complement) exponent input.
- FRC_W, 48, width of raw significand product (1.x * 1.y, value range [1,4)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  stage can accept input this cycle
- in_sign  in  1  product sign (sX ^ sY)
- in_exp  in  EXP_W  signed biased exponent eX+eY-127, assuming product in [1,2)
- in_frc  in  FRC_W  frc_Z_full from MUL
- in_special  in  2  00 normal, 01 zero, 10 inf, 11 NaN (decoded upstream)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_z  out  32  packed IEEE-754 result
- out_ovf  out  1  overflow flag
- out_unf  out  1  underflow (flush) flag
- out_inx  out  1  inexact flag

Behaviour:
- Reset: s1_valid=0, out_valid=0, out_z=0, all flags=0. Reset mid-operation discards in-flight results. First in_ready=1 occurs in the cycle after rst deasserts.
- Handshake:
  - Transfer occurs on valid&ready.
  - in_valid/in_* must hold stable while in_valid&!in_ready.
  - out_z and flags hold stable while out_valid&!out_ready.
- Pipeline:
  - s2 advances when !out_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advance condition, which is combinational from out_ready.
  - Latency is 2 cycles from accept to out_valid with no stall.
  - Throughput is 1 per cycle.
  - Max 2 results in flight. Order is preserved.
- Stage 1 (normalise):
  - If in_frc[47]=1: mant=in_frc[46:24], g=in_frc[23], st=|in_frc[22:0], e=in_exp+1.
  - Otherwise: mant=in_frc[45:23], g=in_frc[22], st=|in_frc[21:0], e=in_exp.
  - Register sign, e, mant, g, st and special.
- Stage 2 (round/pack):
  - inc = g & (st | mant[0]). Compute m' = mant + inc as 24 bits.
  - If carry-out: mant=0, e=e+1.
  - inx = g|st.
  - e >= 255 gives {sign,8'hFF,23'h0}, ovf=1, inx=1.
  - e <= 0 (signed) gives {sign,31'h0}, unf=1, inx=1. Flush to zero, no subnormal output.
  - Otherwise the result is {sign, e[7:0], mant}.
- Specials override the arithmetic result; all flags are 0 for specials:
  - zero: {sign,31'h0}
  - inf: {sign,8'hFF,23'h0}
  - NaN: 32'h7FC00000 (canonical, sign ignored)
- Boundaries:
  - Rounding carry into exponent 255 yields inf with ovf=1.
  - in_exp negative (e.g. -130) yields zero with unf=1.
  - in_frc is ignored when in_special≠00.
  - Simultaneous output accept and input accept with both stages full is legal: no bubble, no loss.

Decomposition:
- Shared package fpm_pkg holds:
  - special-class enum (FPM_NORM, FPM_ZERO, FPM_INF, FPM_NAN)
  - constants FPM_BIAS=127, FPM_EXP_MAX=255, FPM_QNAN=32'h7FC00000
  - packed struct for the stage-1 register (sign, exp, mant, g, st, special)
- One combinational sub-module, fpm_round_rne, covers stage-2 rounding, range check and pack. It is reusable by the future adder path.

Test Plan:
- 1.5*1.5: in_exp=127, in_frc=48'h900000000000, special=00 -> out_z=32'h40100000, flags 0, out_valid exactly 2 cycles after accept.
- Tie to even: in_exp=127, in_frc=48'h400000400000 -> 32'h3F800000, inx=1. in_frc=48'h400000C00000 -> 32'h3F800002, inx=1.
- Rounding carry: in_exp=127, in_frc=48'h7FFFFFC00000 -> 32'h40000000, inx=1.
- Range:
  - in_exp=254, in_frc=48'h800000000000, sign=1 -> 32'hFF800000, ovf=1, inx=1.
  - in_exp=0, in_frc=48'h400000000000, sign=1 -> 32'h80000000, unf=1.
- Specials: special=11 -> 32'h7FC00000; special=10, sign=0 -> 32'h7F800000; special=01, sign=1 -> 32'h80000000; flags 0.
- Back-pressure: stream 4 operands with out_ready=0 for 5 cycles. Required response:
  - in_ready drops after 2 are held.
  - out_z stays stable while stalled.
  - All 4 results emerge in order once out_ready=1.
  - Asserting rst mid-stream clears out_valid on the next edge.

Source files
------------

// File: rtl/fpm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpm_pkg
// Purpose  : Shared types and constants for the FP multiplier back end
//            (normalise / round / pack). Also intended for the adder path.
// Contents : special-class enum, IEEE-754 single constants, stage-1 record.
// Revision : 1.0  initial release
// ============================================================================
package fpm_pkg;

  // Operand class decoded upstream of the multiplier.
  typedef enum logic [1:0] {
    FPM_NORM = 2'b00,
    FPM_ZERO = 2'b01,
    FPM_INF  = 2'b10,
    FPM_NAN  = 2'b11
  } fpm_special_e;

  localparam int          FPM_BIAS    = 127;
  localparam int          FPM_EXP_MAX = 255;
  localparam logic [31:0] FPM_QNAN    = 32'h7FC0_0000;

  // Internal exponent width. Wider than the input exponent so that the
  // normalise increment and the rounding carry can never wrap.
  localparam int          FPM_EIW     = 16;

  // Stage-1 (post-normalise) register contents.
  typedef struct packed {
    logic                      sign;
    logic signed [FPM_EIW-1:0] exp;
    logic [22:0]               mant;
    logic                      g;
    logic                      st;
    fpm_special_e              special;
  } fpm_s1_t;

endpackage : fpm_pkg
`default_nettype wire

// File: rtl/fpm_round_rne.sv
`default_nettype none
// ============================================================================
// Module   : fpm_round_rne
// Purpose  : Combinational round-to-nearest-even, range check and IEEE-754
//            single-precision pack. Subnormals flush to zero.
// Ports    : sign, exp (signed, biased), mant[22:0], g (guard), st (sticky),
//            special (class)           -> inputs
//            z[31:0], ovf, unf, inx    -> outputs
// Revision : 1.0  initial release
// ============================================================================
module fpm_round_rne
  import fpm_pkg::*;
(
  input  logic                      sign,
  input  logic signed [FPM_EIW-1:0] exp,
  input  logic [22:0]               mant,
  input  logic                      g,
  input  logic                      st,
  input  fpm_special_e              special,
  output logic [31:0]               z,
  output logic                      ovf,
  output logic                      unf,
  output logic                      inx
);

  localparam logic signed [FPM_EIW-1:0] E_MAX  = FPM_EIW'(FPM_EXP_MAX);
  localparam logic signed [FPM_EIW-1:0] E_ZERO = '0;

  logic                      inc;
  logic [23:0]               m_rnd;
  logic signed [FPM_EIW-1:0] e_rnd;
  logic [22:0]               mant_rnd;

  always_comb begin
    // Round up on guard when above half (sticky) or exactly half with odd lsb.
    inc      = g & (st | mant[0]);
    m_rnd    = {1'b0, mant} + {23'd0, inc};
    // A carry out of the fraction means 1.111..1 rounded to 10.000..0.
    e_rnd    = exp + {{(FPM_EIW-1){1'b0}}, m_rnd[23]};
    mant_rnd = m_rnd[23] ? 23'd0 : m_rnd[22:0];

    z   = '0;
    ovf = 1'b0;
    unf = 1'b0;
    inx = 1'b0;

    unique case (special)
      FPM_ZERO: z = {sign, 31'h0};
      FPM_INF:  z = {sign, 8'hFF, 23'h0};
      FPM_NAN:  z = FPM_QNAN;
      default: begin
        inx = g | st;
        if (e_rnd >= E_MAX) begin
          z   = {sign, 8'hFF, 23'h0};
          ovf = 1'b1;
          inx = 1'b1;
        end else if (e_rnd <= E_ZERO) begin
          z   = {sign, 31'h0};
          unf = 1'b1;
          inx = 1'b1;
        end else begin
          z = {sign, e_rnd[7:0], mant_rnd};
        end
      end
    endcase
  end

endmodule : fpm_round_rne
`default_nettype wire

// File: rtl/fpm_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : fpm_norm_round
// Purpose  : Two-stage pipelined normalise / round / pack behind the Booth
//            mantissa multiplier, with valid/ready back-pressure.
// Ports    : clk, rst (sync, active high)
//            in_valid/in_ready, in_sign, in_exp[EXP_W], in_frc[FRC_W],
//            in_special[2]                       -> operand side
//            out_valid/out_ready, out_z[32], out_ovf, out_unf, out_inx
//                                                -> result side
// Revision : 1.0  initial release
// ============================================================================
module fpm_norm_round
  import fpm_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int FRC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [FRC_W-1:0] in_frc,
  input  logic [1:0]       in_special,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_inx
);

  logic        ready_en_q, ready_en_d;
  logic        s1_valid_q, s1_valid_d;
  fpm_s1_t     s1_q, s1_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_z_q, out_z_d;
  logic        out_ovf_q, out_ovf_d;
  logic        out_unf_q, out_unf_d;
  logic        out_inx_q, out_inx_d;

  logic                      s2_adv, s1_adv, accept;
  logic signed [FPM_EIW-1:0] exp_ext;
  fpm_s1_t                   norm;
  logic [31:0]               rnd_z;
  logic                      rnd_ovf, rnd_unf, rnd_inx;

  // Stage 1: product lies in [1,4); a set msb means it is in [2,4) and
  // needs a one-place right shift with an exponent bump.
  always_comb begin
    exp_ext      = {{(FPM_EIW-EXP_W){in_exp[EXP_W-1]}}, in_exp};
    norm.sign    = in_sign;
    norm.special = fpm_special_e'(in_special);
    if (in_frc[FRC_W-1]) begin
      norm.mant = in_frc[FRC_W-2 -: 23];
      norm.g    = in_frc[FRC_W-25];
      norm.st   = |in_frc[FRC_W-26:0];
      norm.exp  = exp_ext + FPM_EIW'(1);
    end else begin
      norm.mant = in_frc[FRC_W-3 -: 23];
      norm.g    = in_frc[FRC_W-26];
      norm.st   = |in_frc[FRC_W-27:0];
      norm.exp  = exp_ext;
    end
  end

  fpm_round_rne u_round (
    .sign    (s1_q.sign),
    .exp     (s1_q.exp),
    .mant    (s1_q.mant),
    .g       (s1_q.g),
    .st      (s1_q.st),
    .special (s1_q.special),
    .z       (rnd_z),
    .ovf     (rnd_ovf),
    .unf     (rnd_unf),
    .inx     (rnd_inx)
  );

  always_comb begin
    s2_adv   = !out_valid_q | out_ready;
    s1_adv   = !s1_valid_q | s2_adv;
    // ready_en_q holds ready low for the first cycle out of reset.
    in_ready = ready_en_q & s1_adv;
    accept   = in_valid & in_ready;

    ready_en_d  = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    out_inx_d   = out_inx_q;

    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) s1_d = norm;
    end

    // Result registers only reload with a real result, so they stay stable
    // while stalled and keep the last value across bubbles.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_z_d   = rnd_z;
        out_ovf_d = rnd_ovf;
        out_unf_d = rnd_unf;
        out_inx_d = rnd_inx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_inx_q   <= 1'b0;
    end else begin
      ready_en_q  <= ready_en_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      out_inx_q   <= out_inx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
  assign out_inx   = out_inx_q;

endmodule : fpm_norm_round
`default_nettype wire

// File: tb/tb_fpm_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpm_norm_round
// Purpose  : Directed self-checking bench for fpm_norm_round.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpm_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_frc;
  logic [1:0]  in_special;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inx;

  int n_checks = 0;
  int n_fail   = 0;

  logic        mon_en = 1'b0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  fpm_norm_round #(.EXP_W(10), .FRC_W(48)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_frc     (in_frc),
    .in_special (in_special),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_inx    (out_inx)
  );

  // Records every result that will be consumed on the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (mon_en && out_valid && out_ready && !rst) got_q.push_back(out_z);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] f, input logic [1:0] sp);
    in_valid   = 1'b1;
    in_sign    = s;
    in_exp     = e;
    in_frc     = f;
    in_special = sp;
  endtask

  // Called just after a falling edge with the pipeline empty and out_ready=1.
  task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                         input logic [47:0] f, input logic [1:0] sp,
                         input logic [31:0] exp_z, input logic [2:0] exp_flags);
    drive(s, e, f, sp);
    #1;
    check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check_val({tag, "_z"}, out_z, exp_z);
    check_val({tag, "_flg"}, 32'({out_ovf, out_unf, out_inx}), 32'(exp_flags));
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    #1;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_val({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sign    = 1'b0;
    in_exp     = '0;
    in_frc     = '0;
    in_special = 2'b00;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_z", out_z, 32'h0);
    check_val("rst_flags", 32'({out_ovf, out_unf, out_inx}), 32'd0);
    check_val("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wait_ready("post_rst");

    // flags are {ovf, unf, inx}
    run_vec("mul_1p5",   1'b0, 10'd127, 48'h9000_0000_0000, 2'b00, 32'h4010_0000, 3'b000);
    run_vec("tie_even",  1'b0, 10'd127, 48'h4000_0040_0000, 2'b00, 32'h3F80_0000, 3'b001);
    run_vec("tie_odd",   1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, 32'h3F80_0002, 3'b001);
    run_vec("rnd_carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 2'b00, 32'h4000_0000, 3'b001);
    run_vec("max_norm",  1'b0, 10'd254, 48'h4000_0000_0000, 2'b00, 32'h7F00_0000, 3'b000);
    run_vec("ovf",       1'b1, 10'd254, 48'h8000_0000_0000, 2'b00, 32'hFF80_0000, 3'b101);
    run_vec("carry_ovf", 1'b0, 10'd254, 48'h7FFF_FFC0_0000, 2'b00, 32'h7F80_0000, 3'b101);
    run_vec("unf_e0",    1'b1, 10'd0,   48'h4000_0000_0000, 2'b00, 32'h8000_0000, 3'b011);
    // 10'h37E is -130
    run_vec("unf_neg",   1'b0, 10'h37E, 48'h8000_0000_0000, 2'b00, 32'h0000_0000, 3'b011);
    run_vec("sp_nan",    1'b1, 10'd127, 48'h9000_0000_0001, 2'b11, 32'h7FC0_0000, 3'b000);
    run_vec("sp_inf",    1'b0, 10'd5,   48'h7FFF_FFC0_0000, 2'b10, 32'h7F80_0000, 3'b000);
    run_vec("sp_zero",   1'b1, 10'd254, 48'h8000_0000_0000, 2'b01, 32'h8000_0000, 3'b000);

    // Back-pressure: downstream stalled while four operands are offered.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h9000_0000_0000, 2'b00);
    #1 check_val("bp_rdy_a", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 10'd127, 48'h4000_0040_0000, 2'b00);
    #1 check_val("bp_rdy_b", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00);
    #1 check_val("bp_rdy_drop", 32'(in_ready), 32'd0);
    check_val("bp_valid", 32'(out_valid), 32'd1);
    check_val("bp_hold0", out_z, 32'h4010_0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_val("bp_hold_rdy", 32'(in_ready), 32'd0);
      check_val("bp_hold_z", out_z, 32'h4010_0000);
    end
    @(negedge clk);
    out_ready = 1'b1;
    mon_en    = 1'b1;
    #1 check_val("bp_release_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 2'b00);
    #1 check_val("bp_rdy_d", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check_val("bp_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check_val("bp_res0", got_q[0], 32'h4010_0000);
      check_val("bp_res1", got_q[1], 32'h3F80_0000);
      check_val("bp_res2", got_q[2], 32'h3F80_0002);
      check_val("bp_res3", got_q[3], 32'h4000_0000);
    end

    // Reset mid-stream discards both in-flight results.
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h9000_0000_0000, 2'b00);
    @(negedge clk);
    drive(1'b1, 10'd127, 48'h4000_0040_0000, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("mr_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("mr_valid", 32'(out_valid), 32'd0);
    check_val("mr_z", out_z, 32'h0);
    check_val("mr_ready", 32'(in_ready), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("mr_no_ghost", 32'(seen), 32'd0);
    wait_ready("mr_recover");
    run_vec("mr_after", 1'b1, 10'd127, 48'h9000_0000_0000, 2'b00, 32'hC010_0000, 3'b000);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fpm_norm_round
`default_nettype wire
